pipe_shell: RTL and testbench



---
 rtl/pipe_pkg.sv | 25 ++
 rtl/pipe_stage_reg.sv | 48 ++++
 rtl/pipe_shell.sv | 129 ++++++++++++
 tb/tb_pipe_shell.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared definitions for the in-order pipeline register chain.
// Per-stage record layout, index width helper and stage index clamp.
package pipe_pkg;

    // Record layout: {data, halt, valid}
    localparam int REC_VALID = 0;
    localparam int REC_HALT  = 1;
    localparam int REC_DATA  = 2;

    // Minimum stage index width for a chain of n stages
    function automatic int stage_idx_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // Full record width for a given payload width
    function automatic int rec_width(input int width);
        return width + REC_DATA;
    endfunction

    // Out-of-range stage indices select the oldest stage
    function automatic int clamp_idx(input int idx, input int depth);
        return (idx > depth - 1) ? depth - 1 : idx;
    endfunction

endpackage

// File: rtl/pipe_stage_reg.sv
// One pipeline stage: valid, halt and payload held in a single record.
// Hold beats load beats bubble; clear then drops valid/halt only.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      hold,
    input  logic                      load,
    input  logic                      bubble,
    input  logic                      clear,
    input  logic [WIDTH+REC_DATA-1:0] load_rec,
    output logic [WIDTH+REC_DATA-1:0] rec
);

    logic [WIDTH+REC_DATA-1:0] rec_nxt;

    // Next record: advance/hold/bubble first, then the flush clear
    always_comb begin
        rec_nxt = rec;
        if (hold) begin
            rec_nxt = rec;
        end else if (load) begin
            rec_nxt = load_rec;
        end else if (bubble) begin
            rec_nxt[REC_VALID] = 1'b0;
            rec_nxt[REC_HALT]  = 1'b0;
        end
        if (clear) begin
            // Payload keeps its old value so a flush does not toggle data
            rec_nxt            = rec;
            rec_nxt[REC_VALID] = 1'b0;
            rec_nxt[REC_HALT]  = 1'b0;
        end
    end

    // Stage register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rec <= '0;
        end else begin
            rec <= rec_nxt;
        end
    end

endmodule

// File: rtl/pipe_shell.sv
// Parametrised in-order pipeline shell with stall, ranged flush and halt.
// Stage 0 is youngest; stage DEPTH-1 drives out_valid/out_data.
module pipe_shell
    import pipe_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DEPTH = 5,
    parameter int IDXW  = 3
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    input  logic [WIDTH-1:0]       in_data,
    input  logic                   in_halt,
    output logic                   in_ready,
    input  logic                   stall_req,
    input  logic [IDXW-1:0]        stall_stage,
    input  logic                   flush_req,
    input  logic [IDXW-1:0]        flush_stage,
    output logic [DEPTH-1:0]       stage_valid,
    output logic [DEPTH*WIDTH-1:0] stage_data,
    output logic                   out_valid,
    output logic [WIDTH-1:0]       out_data,
    output logic                   hlt,
    output logic [IDXW:0]          occupancy
);

    localparam int RW = rec_width(WIDTH);

    logic [RW-1:0]    rec      [DEPTH];
    logic [RW-1:0]    load_rec [DEPTH];
    logic [DEPTH-1:0] hold;
    logic [DEPTH-1:0] load;
    logic [DEPTH-1:0] bubble;
    logic [DEPTH-1:0] clear;
    logic             accept;
    logic             set_hlt;
    int               s_lim;
    int               f_lim;

    assign in_ready = !hlt && !stall_req;
    assign accept   = in_valid && in_ready;

    // Entry offered to each stage: new input for 0, older neighbour else
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            load_rec[i] = '0;
        end
        load_rec[0][REC_VALID]             = 1'b1;
        load_rec[0][REC_HALT]              = in_halt;
        load_rec[0][REC_DATA +: WIDTH]     = in_data;
        for (int i = 1; i < DEPTH; i++) begin
            load_rec[i] = rec[i-1];
        end
    end

    // Per-stage control: freeze on halt, else stall/advance, then flush
    always_comb begin
        hold   = '0;
        load   = '0;
        bubble = '0;
        clear  = '0;
        s_lim  = clamp_idx(int'(stall_stage), DEPTH);
        f_lim  = clamp_idx(int'(flush_stage), DEPTH);
        for (int i = 0; i < DEPTH; i++) begin
            priority case (1'b1)
                hlt:                           hold[i]   = 1'b1;
                stall_req && (i <= s_lim):     hold[i]   = 1'b1;
                stall_req && (i == s_lim + 1): bubble[i] = 1'b1;
                (i == 0) && accept:            load[i]   = 1'b1;
                (i == 0):                      bubble[i] = 1'b1;
                default:                       load[i]   = 1'b1;
            endcase
            if (!hlt && flush_req && (i <= f_lim)) begin
                clear[i] = 1'b1;
            end
        end
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_stage
        pipe_stage_reg #(
            .WIDTH (WIDTH)
        ) u_stage (
            .clk      (clk),
            .rst_n    (rst_n),
            .hold     (hold[g]),
            .load     (load[g]),
            .bubble   (bubble[g]),
            .clear    (clear[g]),
            .load_rec (load_rec[g]),
            .rec      (rec[g])
        );
    end

    // A valid halt entry written into the oldest stage raises hlt
    assign set_hlt = load[DEPTH-1] && !clear[DEPTH-1]
                   && load_rec[DEPTH-1][REC_VALID]
                   && load_rec[DEPTH-1][REC_HALT];

    // Sticky halt flag, only reset clears it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hlt <= 1'b0;
        end else if (set_hlt) begin
            hlt <= 1'b1;
        end
    end

    // Flattened stage view and oldest-stage output
    always_comb begin
        stage_valid = '0;
        stage_data  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            stage_valid[i]              = rec[i][REC_VALID];
            stage_data[i*WIDTH +: WIDTH] = rec[i][REC_DATA +: WIDTH];
        end
        out_valid = rec[DEPTH-1][REC_VALID];
        out_data  = rec[DEPTH-1][REC_DATA +: WIDTH];
    end

    // Occupancy as popcount of stage valid bits
    always_comb begin
        occupancy = '0;
        for (int i = 0; i < DEPTH; i++) begin
            occupancy = occupancy + (IDXW+1)'(rec[i][REC_VALID]);
        end
    end

endmodule

// File: tb/tb_pipe_shell.sv
// Self-checking bench for pipe_shell (DEPTH=5, WIDTH=16).
// Cycle table plus scoreboard queue and hand-written corner sequences.
module tb_pipe_shell;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [15:0] in_data;
    logic        in_halt;
    logic        in_ready;
    logic        stall_req;
    logic [2:0]  stall_stage;
    logic        flush_req;
    logic [2:0]  flush_stage;
    logic [4:0]  stage_valid;
    logic [79:0] stage_data;
    logic        out_valid;
    logic [15:0] out_data;
    logic        hlt;
    logic [3:0]  occupancy;

    int errs   = 0;
    int checks = 0;
    logic [15:0] sb [$];

    typedef struct {
        logic        v;
        logic [15:0] d;
        logic        sr;
        logic [2:0]  ss;
        logic        exp_rdy;
        logic [4:0]  exp_sv;
        logic [3:0]  exp_occ;
    } vec_t;

    vec_t tbl [17];

    pipe_shell #(
        .WIDTH (16),
        .DEPTH (5),
        .IDXW  (3)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_halt     (in_halt),
        .in_ready    (in_ready),
        .stall_req   (stall_req),
        .stall_stage (stall_stage),
        .flush_req   (flush_req),
        .flush_stage (flush_stage),
        .stage_valid (stage_valid),
        .stage_data  (stage_data),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .hlt         (hlt),
        .occupancy   (occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [15:0] d, input logic h,
                         input logic sr, input logic [2:0] ss,
                         input logic fr, input logic [2:0] fs);
        in_valid    = v;
        in_data     = d;
        in_halt     = h;
        stall_req   = sr;
        stall_stage = ss;
        flush_req   = fr;
        flush_stage = fs;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sb_check();
        logic [15:0] e;
        if (out_valid) begin
            if (sb.size() == 0) begin
                checks++;
                errs++;
                $display("FAIL sb_extra: got %0h expected none", out_data);
            end else begin
                e = sb.pop_front();
                chk("sb_out", 64'(out_data), 64'(e));
            end
        end
    endtask

    task automatic fill(input logic [15:0] base);
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, base + 16'(i), 1'b0, 1'b0, 3'd0, 1'b0, 3'd0);
            #2;
            sb_check();
            sb.push_back(base + 16'(i));
            tick();
        end
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) begin
            drive(1'b0, 16'h0, 1'b0, 1'b0, 3'd0, 1'b0, 3'd0);
            #2;
            sb_check();
            tick();
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0]  = '{1'b1, 16'h1000, 1'b0, 3'd0, 1'b1, 5'b00000, 4'd0};
        tbl[1]  = '{1'b1, 16'h1001, 1'b0, 3'd0, 1'b1, 5'b00001, 4'd1};
        tbl[2]  = '{1'b1, 16'h1002, 1'b0, 3'd0, 1'b1, 5'b00011, 4'd2};
        tbl[3]  = '{1'b1, 16'h1003, 1'b0, 3'd0, 1'b1, 5'b00111, 4'd3};
        tbl[4]  = '{1'b1, 16'h1004, 1'b0, 3'd0, 1'b1, 5'b01111, 4'd4};
        tbl[5]  = '{1'b1, 16'h1005, 1'b0, 3'd0, 1'b1, 5'b11111, 4'd5};
        tbl[6]  = '{1'b1, 16'h1006, 1'b0, 3'd0, 1'b1, 5'b11111, 4'd5};
        tbl[7]  = '{1'b1, 16'h1007, 1'b1, 3'd1, 1'b0, 5'b11111, 4'd5};
        tbl[8]  = '{1'b1, 16'h1007, 1'b1, 3'd1, 1'b0, 5'b11011, 4'd4};
        tbl[9]  = '{1'b1, 16'h1007, 1'b0, 3'd0, 1'b1, 5'b10011, 4'd3};
        tbl[10] = '{1'b1, 16'h1008, 1'b0, 3'd0, 1'b1, 5'b00111, 4'd3};
        tbl[11] = '{1'b0, 16'h0000, 1'b0, 3'd0, 1'b1, 5'b01111, 4'd4};
        tbl[12] = '{1'b0, 16'h0000, 1'b0, 3'd0, 1'b1, 5'b11110, 4'd4};
        tbl[13] = '{1'b0, 16'h0000, 1'b0, 3'd0, 1'b1, 5'b11100, 4'd3};
        tbl[14] = '{1'b0, 16'h0000, 1'b0, 3'd0, 1'b1, 5'b11000, 4'd2};
        tbl[15] = '{1'b0, 16'h0000, 1'b0, 3'd0, 1'b1, 5'b10000, 4'd1};
        tbl[16] = '{1'b0, 16'h0000, 1'b0, 3'd0, 1'b1, 5'b00000, 4'd0};

        // Reset state
        rst_n = 1'b0;
        drive(1'b0, 16'h0, 1'b0, 1'b0, 3'd0, 1'b0, 3'd0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", 64'(stage_valid), 64'd0);
        chk("rst_hlt", 64'(hlt), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_data", 64'(out_data), 64'd0);
        chk("rst_occ", 64'(occupancy), 64'd0);
        chk("rst_ready", 64'(in_ready), 64'd1);
        rst_n = 1'b1;

        // Stream plus stall bubble, table driven
        for (int c = 0; c < 17; c++) begin
            drive(tbl[c].v, tbl[c].d, 1'b0, tbl[c].sr, tbl[c].ss,
                  1'b0, 3'd0);
            #2;
            chk($sformatf("tbl%0d_ready", c), 64'(in_ready),
                64'(tbl[c].exp_rdy));
            chk($sformatf("tbl%0d_valid", c), 64'(stage_valid),
                64'(tbl[c].exp_sv));
            chk($sformatf("tbl%0d_occ", c), 64'(occupancy),
                64'(tbl[c].exp_occ));
            sb_check();
            if (tbl[c].v && tbl[c].exp_rdy) sb.push_back(tbl[c].d);
            tick();
        end
        chk("stream_sb_empty", 64'(sb.size()), 64'd0);

        // Flush stages 0..2 with a discarded same-cycle input
        fill(16'h00A0);
        drive(1'b1, 16'h00A5, 1'b0, 1'b0, 3'd0, 1'b1, 3'd2);
        #2;
        sb_check();
        tick();
        drive(1'b0, 16'h0, 1'b0, 1'b0, 3'd0, 1'b0, 3'd0);
        chk("flush_valid", 64'(stage_valid), 64'b11000);
        chk("flush_occ", 64'(occupancy), 64'd2);
        chk("flush_s4", 64'(stage_data[64 +: 16]), 64'h00A1);
        void'(sb.pop_back());
        void'(sb.pop_back());
        drain(6);
        chk("flush_sb_empty", 64'(sb.size()), 64'd0);

        // Stall 0..2 with flush 0..3 in the same cycle
        fill(16'h00B0);
        drive(1'b0, 16'h0, 1'b0, 1'b1, 3'd2, 1'b1, 3'd3);
        #2;
        sb_check();
        tick();
        drive(1'b0, 16'h0, 1'b0, 1'b0, 3'd0, 1'b0, 3'd0);
        chk("sf_valid", 64'(stage_valid), 64'b10000);
        chk("sf_occ", 64'(occupancy), 64'd1);
        chk("sf_s4", 64'(stage_data[64 +: 16]), 64'h00B1);
        void'(sb.pop_back());
        void'(sb.pop_back());
        void'(sb.pop_back());
        drain(3);
        chk("sf_sb_empty", 64'(sb.size()), 64'd0);

        // Halt entry reaches the oldest stage and freezes the chain
        drive(1'b1, 16'hDEAD, 1'b1, 1'b0, 3'd0, 1'b0, 3'd0);
        #2;
        sb.push_back(16'hDEAD);
        tick();
        for (int i = 1; i < 5; i++) begin
            drive(1'b0, 16'h0, 1'b0, 1'b0, 3'd0, 1'b0, 3'd0);
            #2;
            sb_check();
            if (i == 4) chk("halt_pre_hlt", 64'(hlt), 64'd0);
            tick();
        end
        #2;
        chk("halt_hlt", 64'(hlt), 64'd1);
        chk("halt_ready", 64'(in_ready), 64'd0);
        chk("halt_out_valid", 64'(out_valid), 64'd1);
        sb_check();
        drive(1'b1, 16'h1234, 1'b0, 1'b1, 3'd0, 1'b0, 3'd0);
        tick();
        drive(1'b1, 16'h1234, 1'b0, 1'b0, 3'd0, 1'b1, 3'd4);
        tick();
        drive(1'b1, 16'h1234, 1'b0, 1'b1, 3'd1, 1'b1, 3'd2);
        tick();
        drive(1'b0, 16'h0, 1'b0, 1'b0, 3'd0, 1'b0, 3'd0);
        #2;
        chk("halt_frz_hlt", 64'(hlt), 64'd1);
        chk("halt_frz_valid", 64'(stage_valid), 64'b10000);
        chk("halt_frz_occ", 64'(occupancy), 64'd1);
        chk("halt_frz_out", 64'(out_data), 64'hDEAD);
        chk("halt_frz_s4", 64'(stage_data[64 +: 16]), 64'hDEAD);

        // Asynchronous reset clears hlt between edges
        rst_n = 1'b0;
        #1;
        chk("arst_hlt", 64'(hlt), 64'd0);
        chk("arst_valid", 64'(stage_valid), 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Asynchronous reset mid-stream
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 16'h00C0 + 16'(i), 1'b0, 1'b0, 3'd0, 1'b0, 3'd0);
            tick();
        end
        drive(1'b0, 16'h0, 1'b0, 1'b0, 3'd0, 1'b0, 3'd0);
        #3;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 64'(stage_valid), 64'd0);
        chk("mid_rst_occ", 64'(occupancy), 64'd0);
        chk("mid_rst_hlt", 64'(hlt), 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Clamp: stall_stage=7 freezes every stage with no bubble
        fill(16'h00D0);
        drive(1'b1, 16'h00EE, 1'b0, 1'b1, 3'd7, 1'b0, 3'd0);
        #2;
        chk("clamp_ready", 64'(in_ready), 64'd0);
        sb_check();
        tick();
        drive(1'b0, 16'h0, 1'b0, 1'b0, 3'd0, 1'b0, 3'd0);
        chk("clamp_valid", 64'(stage_valid), 64'b11111);
        chk("clamp_s4", 64'(stage_data[64 +: 16]), 64'h00D0);
        chk("clamp_s0", 64'(stage_data[0 +: 16]), 64'h00D4);
        tick();
        drain(6);
        chk("clamp_sb_empty", 64'(sb.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
